// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon128/256 round-key expander.
package simon_pkg;

    localparam int WORD_W     = 64;
    localparam int KEY_WORDS  = 4;
    localparam int NUM_ROUNDS = 72;
    localparam int Z_LEN      = 62;

    localparam logic [WORD_W-1:0] C  = 64'hFFFF_FFFF_FFFF_FFFC;
    // Index 0 of the sequence is the MSB of this literal.
    localparam logic [Z_LEN-1:0]  Z4 =
        62'b1101_0001_1110_0110_1011_0110_0010_0000_0101_1100_0011_0010_1001_0011_1011_11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic z4_bit(input logic [5:0] j);
        return Z4[6'd61 - j];
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// One step of the Simon128/256 key schedule: derives the next key word.
module simon_key_step #(
    parameter int WORD_W = simon_pkg::WORD_W
) (
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w3,
    input  logic              zbit,
    output logic [WORD_W-1:0] knew
);

    logic [WORD_W-1:0] t0;
    logic [WORD_W-1:0] t1;

    assign t0   = {w3[2:0], w3[WORD_W-1:3]} ^ w1;
    assign t1   = t0 ^ {t0[0], t0[WORD_W-1:1]};
    assign knew = WORD_W'(simon_pkg::C) ^ {{(WORD_W-1){1'b0}}, zbit} ^ w0 ^ t1;

endmodule

// File: rtl/simon_key_expand.sv
// Simon128/256 key expander: streams 72 round keys over a valid/ready port
// after a start pulse, one key per cycle when the consumer never stalls.
module simon_key_expand #(
    parameter int KEYLEN_BYTES = 32,
    parameter int WORD_W       = 64,
    parameter int NUM_ROUNDS   = 72
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [KEYLEN_BYTES*8-1:0] init_key,
    input  logic                      key_compute_start,
    output logic [WORD_W-1:0]         rk_data,
    output logic [6:0]                rk_idx,
    output logic                      rk_valid,
    input  logic                      rk_ready,
    output logic                      busy,
    output logic                      done
);
    import simon_pkg::*;

    localparam logic [6:0] LAST_IDX = 7'(NUM_ROUNDS - 1);
    localparam logic [5:0] Z_LAST   = 6'(Z_LEN - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] w_q [KEY_WORDS];
    logic [WORD_W-1:0] w_d [KEY_WORDS];
    logic [6:0]        idx_q, idx_d;
    logic [5:0]        j_q, j_d;
    logic              done_q, done_d;
    logic              zbit;
    logic [WORD_W-1:0] knew;

    assign zbit = z4_bit(j_q);

    simon_key_step #(.WORD_W(WORD_W)) u_step (
        .w0   (w_q[0]),
        .w1   (w_q[1]),
        .w3   (w_q[3]),
        .zbit (zbit),
        .knew (knew)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        idx_d   = idx_q;
        j_d     = j_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_compute_start) begin
                    for (int i = 0; i < KEY_WORDS; i++) begin
                        w_d[i] = init_key[i*WORD_W +: WORD_W];
                    end
                    idx_d   = '0;
                    j_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rk_ready) begin
                    w_d[0] = w_q[1];
                    w_d[1] = w_q[2];
                    w_d[2] = w_q[3];
                    w_d[3] = knew;
                    j_d    = (j_q == Z_LAST) ? 6'd0 : j_q + 6'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < KEY_WORDS; i++) begin
                w_q[i] <= '0;
            end
            idx_q  <= '0;
            j_q    <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            done_q  <= done_d;
        end
    end

    // Data is masked outside RUN so a stale w[0] never leaks after completion.
    assign rk_valid = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN);
    assign rk_data  = rk_valid ? w_q[0] : '0;
    assign rk_idx   = idx_q;
    assign done     = done_q;

endmodule
